m2_ws_writer: RTL



---
 rtl/m2_pkg.sv | 21 ++
 rtl/m2_clip8.sv | 21 ++
 rtl/m2_ws_writer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/m2_pkg.sv
// Shared definitions for the Milestone-2 datapath blocks:
// writer FSM states, plane encodings and sample/pixel widths.
package m2_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LI0  = 3'd1,
        LI1  = 3'd2,
        CC   = 3'd3,
        LO   = 3'd4,
        DONE = 3'd5
    } M2_WS_state_type;

    localparam logic [1:0] PLANE_Y = 2'd0;
    localparam logic [1:0] PLANE_U = 2'd1;
    localparam logic [1:0] PLANE_V = 2'd2;

    localparam int S_WIDTH   = 32;
    localparam int PIX_WIDTH = 8;

endpackage

// File: rtl/m2_clip8.sv
// Saturates one signed S value to an unsigned 8-bit pixel.
// Purely combinational; instantiated once per RAM read port.
module m2_clip8 import m2_pkg::*; (
    input  logic signed [S_WIDTH-1:0]   s_val,
    output logic        [PIX_WIDTH-1:0] pix
);

    function automatic logic [PIX_WIDTH-1:0] sat_u8(input logic signed [S_WIDTH-1:0] v);
        logic [PIX_WIDTH-1:0] r;
        if (v < 32'sd0)
            r = '0;
        else if (v > 32'sd255)
            r = '1;
        else
            r = v[PIX_WIDTH-1:0];
        return r;
    endfunction

    assign pix = sat_u8(s_val);

endmodule

// File: rtl/m2_ws_writer.sv
// Drains one 8x8 block of signed S values from the Cs RAM, clips each to
// 8 bits, packs horizontal pixel pairs into 16-bit words and writes the
// 32 words to the block's location in the Y, U or V plane of SRAM.
// Optional build macro M2_WS_CHECKSUM_EN adds a running 16-bit sum of
// the written words on output ws_checksum.
module m2_ws_writer import m2_pkg::*; #(
    parameter int          Y_WIDTH_WORDS  = 160,
    parameter int          UV_WIDTH_WORDS = 80,
    parameter logic [17:0] Y_BASE         = 18'd0,
    parameter logic [17:0] U_BASE         = 18'd38400,
    parameter logic [17:0] V_BASE         = 18'd57600
) (
    input  logic                      Clock,
    input  logic                      resetn,
    input  logic                      M2_WS_start,
    input  logic [4:0]                block_row,
    input  logic [5:0]                block_col,
    input  logic [1:0]                plane_sel,
    output logic [5:0]                ram_addr_a,
    output logic [5:0]                ram_addr_b,
    input  logic signed [S_WIDTH-1:0] ram_q_a,
    input  logic signed [S_WIDTH-1:0] ram_q_b,
    output logic [17:0]               SRAM_address,
    output logic [15:0]               SRAM_write_data,
    output logic                      SRAM_we_n,
    output logic                      M2_WS_done
`ifdef M2_WS_CHECKSUM_EN
    ,
    output logic [15:0]               ws_checksum
`endif
);

    localparam logic [17:0] Y_W  = 18'(Y_WIDTH_WORDS);
    localparam logic [17:0] UV_W = 18'(UV_WIDTH_WORDS);

    M2_WS_state_type state;

    logic [4:0]  row_q;
    logic [5:0]  col_q;
    logic [1:0]  plane_q;

    // Bit 5 marks that all 32 word addresses have been issued.
    logic [5:0]  fetch_k;
    logic        fetch_en;
    logic        vld_p0;
    logic        vld_p1;
    logic [4:0]  wr_cnt;

    logic signed [S_WIDTH-1:0] q_a_p1;
    logic signed [S_WIDTH-1:0] q_b_p1;
    logic [PIX_WIDTH-1:0]      pix_a_p1;
    logic [PIX_WIDTH-1:0]      pix_b_p1;

    logic [17:0] wr_addr;
    logic [17:0] w_words;
    logic [17:0] base_addr;
    logic [17:0] start_addr;
    logic [17:0] row_step;

    // Plane geometry and first SRAM address of the latched block.
    always_comb begin
        w_words   = (plane_q == PLANE_Y) ? Y_W : UV_W;
        case (plane_q)
            PLANE_Y: base_addr = Y_BASE;
            PLANE_U: base_addr = U_BASE;
            default: base_addr = V_BASE;
        endcase
        start_addr = base_addr
                   + (({13'd0, row_q} << 3) * w_words)
                   + ({12'd0, col_q} << 2);
        row_step   = w_words - 18'd3;
        fetch_en   = ((state == LI0) || (state == LI1) || (state == CC)) && !fetch_k[5];
    end

    m2_clip8 u_clip_a (.s_val(q_a_p1), .pix(pix_a_p1));
    m2_clip8 u_clip_b (.s_val(q_b_p1), .pix(pix_b_p1));

    // Control path: FSM, fetch/write counters, valids and registered outputs.
    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            fetch_k         <= '0;
            wr_cnt          <= '0;
            vld_p0          <= 1'b0;
            vld_p1          <= 1'b0;
            ram_addr_a      <= 6'd0;
            ram_addr_b      <= 6'd1;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            M2_WS_done      <= 1'b0;
`ifdef M2_WS_CHECKSUM_EN
            ws_checksum     <= '0;
`endif
        end else begin
            M2_WS_done <= 1'b0;

            // Stage p0: issue the even/odd addresses of word fetch_k.
            vld_p0 <= fetch_en;
            if (fetch_en) begin
                ram_addr_a <= {fetch_k[4:0], 1'b0};
                ram_addr_b <= {fetch_k[4:0], 1'b1};
                fetch_k    <= fetch_k + 6'd1;
            end

            // Stage p1: RAM data captured (see data path); p2: SRAM write.
            vld_p1    <= vld_p0;
            SRAM_we_n <= !vld_p1;
            if (vld_p1) begin
                SRAM_address    <= wr_addr;
                SRAM_write_data <= {pix_a_p1, pix_b_p1};
                wr_cnt          <= wr_cnt + 5'd1;
            end

`ifdef M2_WS_CHECKSUM_EN
            if ((state == IDLE) && M2_WS_start)
                ws_checksum <= '0;
            else if (vld_p1)
                ws_checksum <= ws_checksum + {pix_a_p1, pix_b_p1};
`endif

            case (state)
                IDLE: begin
                    if (M2_WS_start) begin
                        state   <= LI0;
                        fetch_k <= '0;
                        wr_cnt  <= '0;
                    end
                end
                LI0:  state <= LI1;
                LI1:  state <= CC;
                CC: begin
                    if (vld_p1 && (wr_cnt == 5'd31))
                        state <= LO;
                end
                LO: begin
                    M2_WS_done <= 1'b1;
                    state      <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Data path: block latch, RAM capture and incremental SRAM address.
    always_ff @(posedge Clock) begin
        if ((state == IDLE) && M2_WS_start) begin
            row_q   <= block_row;
            col_q   <= block_col;
            plane_q <= plane_sel;
        end

        if (vld_p0) begin
            q_a_p1 <= ram_q_a;
            q_b_p1 <= ram_q_b;
        end

        if (state == LI0)
            wr_addr <= start_addr;
        else if (vld_p1)
            wr_addr <= wr_addr + ((wr_cnt[1:0] == 2'd3) ? row_step : 18'd1);
    end

endmodule
